// File: rtl/wddl_round_seq.sv
// wddl_round_seq: phase and round sequencer for the WDDL dual-rail AES datapath.
// Every evaluate phase follows at least PRE_CYC precharge cycles. In each precharge
// cycle the datapath inputs are forced to 0/0, so every dual-rail net discharges before
// the next evaluation.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start, datapath held in precharge
// LOAD  | one cycle: plaintext^key0 captured into the state register
// PRE   | precharge phase of the current round (PRE_CYC cycles)
// EVAL  | evaluate phase of the current round (EVAL_CYC cycles)
// DONE  | one cycle: ciphertext valid, may restart straight into LOAD
module wddl_round_seq #(
  parameter int NUM_ROUNDS = 10,
  parameter int PRE_CYC    = 1,
  parameter int EVAL_CYC   = 1,
  parameter int RND_W      = 4,
  parameter int PH_W       = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_load,
  output logic             o_prech,
  output logic             o_reg_en,
  output logic [RND_W-1:0] o_round_idx,
  output logic             o_last_round
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PRE  = 3'd2,
    S_EVAL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [PH_W-1:0]  PRE_LAST  = PH_W'(PRE_CYC - 1);
  localparam logic [PH_W-1:0]  EVAL_LAST = PH_W'(EVAL_CYC - 1);
  localparam logic [RND_W-1:0] RND_LAST  = RND_W'(NUM_ROUNDS);

  state_t           r_state;
  logic [PH_W-1:0]  r_cnt;
  logic [RND_W-1:0] r_round;

  state_t           w_state_nxt;
  logic [PH_W-1:0]  w_cnt_nxt;
  logic [RND_W-1:0] w_round_nxt;

  // State, phase counter and round index registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_round <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_round <= w_round_nxt;
    end
  end

  // Next-state logic. Abort wins over everything while busy; start is only
  // looked at in IDLE and DONE, so a start during an operation is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_round_nxt = r_round;
    case (r_state)
      S_IDLE: begin
        w_round_nxt = '0;
        if (i_start) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
          w_round_nxt = '0;
        end else begin
          w_state_nxt = S_PRE;
          w_round_nxt = RND_W'(1);
        end
      end
      S_PRE: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
          w_round_nxt = '0;
        end else if (r_cnt == PRE_LAST) begin
          w_state_nxt = S_EVAL;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_EVAL: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
          w_round_nxt = '0;
        end else if (r_cnt == EVAL_LAST) begin
          if (r_round == RND_LAST) begin
            w_state_nxt = S_DONE;
            w_round_nxt = '0;
          end else begin
            w_state_nxt = S_PRE;
            w_round_nxt = r_round + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_round_nxt = '0;
        w_state_nxt = i_start ? S_LOAD : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_round_nxt = '0;
      end
    endcase
  end

  // Moore outputs from the registered state. The only input in the output path
  // is abort on reg_en: an aborted round must not write a partial result.
  always_comb begin
    o_busy       = (r_state == S_LOAD) || (r_state == S_PRE) || (r_state == S_EVAL);
    o_done       = (r_state == S_DONE);
    o_load       = (r_state == S_LOAD);
    o_prech      = (r_state != S_EVAL);
    o_reg_en     = (r_state == S_EVAL) && (r_cnt == EVAL_LAST) && !i_abort;
    o_round_idx  = r_round;
    o_last_round = ((r_state == S_PRE) || (r_state == S_EVAL)) && (r_round == RND_LAST);
  end

endmodule
